fila_escrita_reg: RTL and testbench
===================================

Name: fila_escrita_reg

Overview:
- Write-back queue that acts as the producer side of the register file's single write port. It drives the write-register number, write data and write-enable into the register file.
- Result sources (ALU, load unit, multi-cycle units) push {register, data} entries into a small in-order FIFO. The block drains one entry per cycle into the register file and pauses draining while the CPU is halted.
- A scoreboard reports whether a source register still has a pending write, so decode can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DATA_W, 32, data width of an entry; matches the register-file data width.
- ADDR_W, 5, register-number width (32 registers).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- is_halt  in  1  CPU halted; suppresses draining and the write-enable.
- req_valid  in  1  source offers an entry this cycle.
- req_ready  out  1  entry accepted this cycle; equals !full.
- req_reg  in  ADDR_W  destination register of the offered entry.
- req_data  in  DATA_W  data of the offered entry.
- reg_escrita  out  ADDR_W  to register-file write address.
- escreve_dado  out  DATA_W  to register-file write data.
- escreve_reg  out  1  to register-file write enable.
- query_a  in  ADDR_W  rs register number to check.
- query_b  in  ADDR_W  rt register number to check.
- busy_a  out  1  pending write to query_a.
- busy_b  out  1  pending write to query_b.
- count  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (async, reset_n=0):
  - All entries invalid; head and tail pointers = 0; count = 0.
  - escreve_reg = 0, reg_escrita = 0, escreve_dado = 0, req_ready = 1, busy_a = busy_b = 0.
- Push:
  - Occurs on a rising edge when req_valid && req_ready.
  - The entry is written at tail, then tail advances mod DEPTH and count increments.
  - If req_reg == 0, the handshake completes but nothing is stored and count is unchanged.
- Write port (combinational from head):
  - escreve_reg = (count != 0) && !is_halt.
  - reg_escrita and escreve_dado come from the head entry; they are forced to 0 when count == 0.
- Pop:
  - Occurs on the rising edge when escreve_reg = 1; head advances mod DEPTH. The register file captures the entry on that same edge.
- Latency: an entry pushed at edge N is at the head after N. If the queue was empty and is_halt=0, it is written into the register file at edge N+1.
- Ordering: strict FIFO. Two entries to the same register are written oldest first, so the last write wins.
- Simultaneous push and pop: both take effect and count is unchanged.
  - Full queue: req_ready=0 even when a pop occurs that cycle. There is no ready-through path.
  - Empty queue: the pushed entry is not written in the same cycle; there is no bypass to the port.
- Full/empty:
  - req_ready = (count != DEPTH).
  - count never exceeds DEPTH and never goes below 0.
  - Pointers wrap from DEPTH-1 to 0.
- Halt:
  - is_halt=1 freezes head, so queued entries are held with escreve_reg=0.
  - Pushes are still accepted while the queue is not full.
  - Draining resumes on the first cycle with is_halt=0.
- Scoreboard:
  - busy_x = 1 iff some valid entry has reg == query_x. It is combinational.
  - query_x == 0 always gives busy_x = 0.
  - An entry being popped this cycle still reports busy.
- Reset mid-operation: all pending entries are discarded and no further write-enables are issued until a new push arrives.

Optional Feature:
- Macro: FILA_ESCRITA_FWD_EN.
- When defined, two extra outputs are added: fwd_data_a and fwd_data_b, each DATA_W wide.
  - fwd_data_x is the data of the youngest valid entry whose reg == query_x, or 0 when busy_x = 0.
  - This lets decode forward the value instead of stalling.
- When undefined, these ports and their selection logic do not exist; the scoreboard is unchanged.

Test Plan:
- Reset with the FIFO full -> the next cycle shows count=0, escreve_reg=0, req_ready=1, busy_a=busy_b=0.
- Push {r5, 0xDEADBEEF} into an empty queue with is_halt=0 -> the following cycle shows escreve_reg=1, reg_escrita=5, escreve_dado=0xDEADBEEF; after that edge, count=0.
- Push r3=0x11 then r3=0x22 under halt, then release -> writes appear in order 0x11 then 0x22. busy_a (query_a=3) stays 1 until after the second pop. With FWD_EN, fwd_data_a=0x22.
- Push 4 entries with is_halt=1 -> count=4 and req_ready=0; a fifth req_valid is not accepted; on release, 4 writes occur on consecutive cycles.
- Push req_reg=0 with data 0x55 -> req_ready=1, count unchanged, escreve_reg never asserted; query_a=0 gives busy_a=0.
- Full queue, is_halt=0, req_valid=1 -> the pop occurs and the push is refused that cycle (count 4→3). The push is accepted the next cycle (count back to 4).

Source files
------------

// File: rtl/fila_escrita_reg.sv
// -----------------------------------------------------------------------------
// fila_escrita_reg
//
// Write-back queue feeding the register file's single write port. Result
// sources push {register, data} entries into a small in-order FIFO; one entry
// drains per cycle into the register file unless the CPU is halted. A
// scoreboard tells decode whether a source register still has a write pending.
//
// Parameters:
//   DEPTH   number of FIFO entries (power of two, >= 2)
//   DATA_W  entry data width (register-file data width)
//   ADDR_W  register-number width
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   is_halt       CPU halted: holds the head entry, write-enable low
//   req_valid     source offers an entry
//   req_ready     entry accepted this cycle (queue not full)
//   req_reg       destination register of the offered entry (0 = discard)
//   req_data      data of the offered entry
//   reg_escrita   register-file write address (head entry, 0 when empty)
//   escreve_dado  register-file write data (head entry, 0 when empty)
//   escreve_reg   register-file write enable
//   query_a/b     register numbers to check for pending writes
//   busy_a/b      a valid entry targets query_a/b
//   count         number of valid entries
//
// Optional feature (macro FILA_ESCRITA_FWD_EN):
//   fwd_data_a/b  data of the youngest valid entry targeting query_a/b,
//                 0 when that query is not busy
// -----------------------------------------------------------------------------
module fila_escrita_reg #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     is_halt,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_reg,
    input  logic [DATA_W-1:0]        req_data,
    output logic [ADDR_W-1:0]        reg_escrita,
    output logic [DATA_W-1:0]        escreve_dado,
    output logic                     escreve_reg,
    input  logic [ADDR_W-1:0]        query_a,
    input  logic [ADDR_W-1:0]        query_b,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic [$clog2(DEPTH):0]   count
`ifdef FILA_ESCRITA_FWD_EN
    ,
    output logic [DATA_W-1:0]        fwd_data_a,
    output logic [DATA_W-1:0]        fwd_data_b
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] entryReg  [DEPTH];
    logic [DATA_W-1:0] entryData [DEPTH];
    logic [DEPTH-1:0]  entryValid;
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;

    logic isEmpty;
    logic doPush;
    logic doPop;

    assign isEmpty   = (count == '0);
    assign req_ready = (count != FULL_COUNT);

    // A push to r0 completes the handshake but stores nothing.
    assign doPush = req_valid && req_ready && (req_reg != '0);

    assign escreve_reg  = !isEmpty && !is_halt;
    assign doPop        = escreve_reg;
    assign reg_escrita  = isEmpty ? '0 : entryReg[headPtr];
    assign escreve_dado = isEmpty ? '0 : entryData[headPtr];

    // Pointers, count and valid bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            entryValid <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            // Push and pop never hit the same slot: a pop needs a non-empty
            // queue and a push a non-full one, so head != tail when both fire.
            if (doPush) begin
                entryValid[tailPtr] <= 1'b1;
                tailPtr             <= tailPtr + PTR_W'(1);
            end
            if (doPop) begin
                entryValid[headPtr] <= 1'b0;
                headPtr             <= headPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the entry payload is not reset; the valid bits and count gate
    // every use of it, so clearing the storage would buy nothing.
    always_ff @(posedge clock) begin
        if (doPush) begin
            entryReg[tailPtr]  <= req_reg;
            entryData[tailPtr] <= req_data;
        end
    end

    // Scoreboard: an entry being popped this cycle is still valid here, so it
    // keeps reporting busy until the edge that retires it.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && (entryReg[i] == query_a)) busy_a = 1'b1;
            if (entryValid[i] && (entryReg[i] == query_b)) busy_b = 1'b1;
        end
        if (query_a == '0) busy_a = 1'b0;
        if (query_b == '0) busy_b = 1'b0;
    end

`ifdef FILA_ESCRITA_FWD_EN
    // Walk from oldest (head) to youngest; a later match overwrites an
    // earlier one, so the youngest matching entry wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_data_a = '0;
        fwd_data_b = '0;
        idx        = headPtr;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr + PTR_W'(k);
            if (entryValid[idx] && (entryReg[idx] == query_a) && (query_a != '0))
                fwd_data_a = entryData[idx];
            if (entryValid[idx] && (entryReg[idx] == query_b) && (query_b != '0))
                fwd_data_b = entryData[idx];
        end
    end
`endif

endmodule

// File: tb/tb_fila_escrita_reg.sv
// -----------------------------------------------------------------------------
// tb_fila_escrita_reg
//
// Directed self-checking bench for fila_escrita_reg (DEPTH=4, DATA_W=32,
// ADDR_W=5). Inputs change 1 time unit after a rising edge; outputs are
// compared 1 unit later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fila_escrita_reg;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clock;
    logic              reset_n;
    logic              is_halt;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_reg;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] reg_escrita;
    logic [DATA_W-1:0] escreve_dado;
    logic              escreve_reg;
    logic [ADDR_W-1:0] query_a;
    logic [ADDR_W-1:0] query_b;
    logic              busy_a;
    logic              busy_b;
    logic [2:0]        count;
`ifdef FILA_ESCRITA_FWD_EN
    logic [DATA_W-1:0] fwd_data_a;
    logic [DATA_W-1:0] fwd_data_b;
`endif

    int numChecks = 0;
    int numFails  = 0;

    fila_escrita_reg #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .is_halt     (is_halt),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_reg     (req_reg),
        .req_data    (req_data),
        .reg_escrita (reg_escrita),
        .escreve_dado(escreve_dado),
        .escreve_reg (escreve_reg),
        .query_a     (query_a),
        .query_b     (query_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
        .count       (count)
`ifdef FILA_ESCRITA_FWD_EN
        ,
        .fwd_data_a  (fwd_data_a),
        .fwd_data_b  (fwd_data_b)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge, leaving 1 unit of settle time.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_reg   = r;
        req_data  = d;
    endtask

    initial begin
        reset_n   = 1'b0;
        is_halt   = 1'b0;
        req_valid = 1'b0;
        req_reg   = '0;
        req_data  = '0;
        query_a   = '0;
        query_b   = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_count",   32'(count), 0);
        check("rst_we",      32'(escreve_reg), 0);
        check("rst_ready",   32'(req_ready), 1);
        check("rst_addr",    32'(reg_escrita), 0);
        check("rst_data",    escreve_dado, 0);
        check("rst_busy_a",  32'(busy_a), 0);
        check("rst_busy_b",  32'(busy_b), 0);
        reset_n = 1'b1;
        step();

        // ---------------- single push, drain next edge ----------------
        offer(5'd5, 32'hDEADBEEF);
        query_a = 5'd5;
        #1;
        check("p1_ready",    32'(req_ready), 1);
        check("p1_nobypass", 32'(escreve_reg), 0);
        step();
        req_valid = 1'b0;
        #1;
        check("p1_we",       32'(escreve_reg), 1);
        check("p1_addr",     32'(reg_escrita), 5);
        check("p1_data",     escreve_dado, 32'hDEADBEEF);
        check("p1_count",    32'(count), 1);
        check("p1_busy",     32'(busy_a), 1);
        step();
        check("p1_count0",   32'(count), 0);
        check("p1_we0",      32'(escreve_reg), 0);
        check("p1_busy0",    32'(busy_a), 0);

        // ---------------- same register twice under halt ----------------
        is_halt = 1'b1;
        query_a = 5'd3;
        offer(5'd3, 32'h11);
        step();
        offer(5'd3, 32'h22);
        step();
        req_valid = 1'b0;
        #1;
        check("raw_count",   32'(count), 2);
        check("raw_we_halt", 32'(escreve_reg), 0);
        check("raw_busy",    32'(busy_a), 1);
`ifdef FILA_ESCRITA_FWD_EN
        check("raw_fwd",     fwd_data_a, 32'h22);
`endif
        is_halt = 1'b0;
        #1;
        check("raw_we1",     32'(escreve_reg), 1);
        check("raw_data1",   escreve_dado, 32'h11);
        check("raw_busy1",   32'(busy_a), 1);
        step();
        check("raw_data2",   escreve_dado, 32'h22);
        check("raw_busy2",   32'(busy_a), 1);
        check("raw_count1",  32'(count), 1);
        step();
        check("raw_count0",  32'(count), 0);
        check("raw_busy0",   32'(busy_a), 0);

        // ---------------- fill under halt, refuse fifth, wrap drain ----------------
        is_halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(ADDR_W'(i + 1), 32'hA0 + 32'(i));
            step();
            check("fill_count", 32'(count), 32'(i + 1));
        end
        check("fill_ready",  32'(req_ready), 0);
        offer(5'd7, 32'h77);
        query_b = 5'd7;
        step();
        req_valid = 1'b0;
        #1;
        check("fill_refuse", 32'(count), 4);
        check("fill_busy7",  32'(busy_b), 0);
        is_halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drain_we",   32'(escreve_reg), 1);
            check("drain_addr", 32'(reg_escrita), 32'(i + 1));
            check("drain_data", escreve_dado, 32'hA0 + 32'(i));
            step();
        end
        check("drain_count", 32'(count), 0);
        check("drain_we0",   32'(escreve_reg), 0);

        // ---------------- push to r0 is discarded ----------------
        offer(5'd0, 32'h55);
        query_a = 5'd0;
        #1;
        check("r0_ready",    32'(req_ready), 1);
        check("r0_busy",     32'(busy_a), 0);
        step();
        check("r0_count",    32'(count), 0);
        check("r0_we",       32'(escreve_reg), 0);
        step();
        req_valid = 1'b0;
        #1;
        check("r0_count2",   32'(count), 0);
        check("r0_we2",      32'(escreve_reg), 0);

        // ---------------- full queue: pop happens, push refused ----------------
        is_halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(ADDR_W'(i + 8), 32'hB0 + 32'(i));
            step();
        end
        offer(5'd12, 32'hCC);
        query_b = 5'd12;
        is_halt = 1'b0;
        #1;
        check("full_ready",  32'(req_ready), 0);
        check("full_we",     32'(escreve_reg), 1);
        check("full_addr",   32'(reg_escrita), 8);
        step();
        check("full_count3", 32'(count), 3);
        check("full_busy12", 32'(busy_b), 0);
        is_halt = 1'b1;
        #1;
        check("full_ready1", 32'(req_ready), 1);
        step();
        req_valid = 1'b0;
        #1;
        check("full_count4", 32'(count), 4);
        check("full_busy12b", 32'(busy_b), 1);
        check("full_head",   32'(reg_escrita), 9);
`ifdef FILA_ESCRITA_FWD_EN
        check("full_fwd",    fwd_data_b, 32'hCC);
`endif

        // ---------------- reset mid-operation ----------------
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_count",  32'(count), 0);
        check("mrst_we",     32'(escreve_reg), 0);
        check("mrst_ready",  32'(req_ready), 1);
        check("mrst_busy_b", 32'(busy_b), 0);
        check("mrst_addr",   32'(reg_escrita), 0);
        step();
        reset_n = 1'b1;
        is_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mrst_idle_we", 32'(escreve_reg), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 numChecks, numFails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
